// File: rtl/fb_filler_pkg.sv
// Shared encodings for the frame-buffer filler: fill patterns and FSM states.
package fb_filler_pkg;

   typedef enum logic [1:0] {
      MODE_SOLID  = 2'd0,
      MODE_RAMP   = 2'd1,
      MODE_NIBBLE = 2'd2,
      MODE_XOR    = 2'd3
   } fill_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
      ST_PACE   = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

endpackage

// File: rtl/fb_pattern_gen.sv
// Data-pattern generator: maps the current word offset to the write data.
module fb_pattern_gen
   import fb_filler_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  fill_mode_e        mode,
   input  logic [DATA_W-1:0] fill_value,
   input  logic [DATA_W-1:0] offset,
   output logic [DATA_W-1:0] data
);

   // Select the pattern for the current offset.
   always_comb begin
      data = '0;
      case (mode)
         MODE_SOLID:  data = fill_value;
         MODE_RAMP:   data = offset;
         MODE_NIBBLE: data = {(DATA_W/4){offset[3:0]}};
         MODE_XOR:    data = fill_value ^ offset;
         default:     data = '0;
      endcase
   end

endmodule

// File: rtl/fb_filler.sv
// Frame-buffer filler: writes a generated pattern to count consecutive
// word addresses starting at base, with optional idle pacing between writes.
module fb_filler
   import fb_filler_pkg::*;
#(
   parameter int ADDR_W = 26,
   parameter int DATA_W = 8,
   parameter int PACE_W = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] count,
   input  logic [DATA_W-1:0] fill_value,
   input  logic [PACE_W-1:0] pace,
   output logic [ADDR_W-1:0] o_address,
   output logic [DATA_W-1:0] o_data,
   output logic              o_we,
   input  logic              i_ready,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   state_e            state, state_nxt;
   fill_mode_e        mode_q;
   logic [ADDR_W-1:0] base_q, count_q, offset, offset_inc;
   logic [DATA_W-1:0] fill_q;
   logic [PACE_W-1:0] pace_q, pace_cnt;
   logic              last_word;

   assign offset_inc = offset + ADDR_W'(1);
   assign last_word  = (offset_inc == count_q);
   assign o_address  = base_q + offset;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      state_nxt = state;
      o_we      = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = (count == '0) ? ST_FINISH : ST_WRITE;
         end
         ST_WRITE: begin
            o_we = 1'b1;
            // abort wins over a same-cycle acceptance
            if (abort)               state_nxt = ST_IDLE;
            else if (i_ready) begin
               if (last_word)        state_nxt = ST_FINISH;
               else if (pace_q != '0) state_nxt = ST_PACE;
            end
         end
         ST_PACE: begin
            if (abort)                           state_nxt = ST_IDLE;
            else if (pace_cnt == PACE_W'(1))     state_nxt = ST_WRITE;
         end
         ST_FINISH: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Operation parameters, word offset, pacing counter and abort pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_q   <= MODE_SOLID;
         base_q   <= '0;
         count_q  <= '0;
         fill_q   <= '0;
         pace_q   <= '0;
         pace_cnt <= '0;
         offset   <= '0;
         aborted  <= 1'b0;
      end else begin
         aborted <= abort && (state == ST_WRITE || state == ST_PACE);
         if (state == ST_IDLE && start) begin
            mode_q  <= fill_mode_e'(mode);
            base_q  <= base;
            count_q <= count;
            fill_q  <= fill_value;
            pace_q  <= pace;
            offset  <= '0;
         end else if (state == ST_WRITE && i_ready && !abort) begin
            offset   <= offset_inc;
            pace_cnt <= pace_q;
         end else if (state == ST_PACE) begin
            pace_cnt <= pace_cnt - PACE_W'(1);
         end
      end
   end

   fb_pattern_gen #(.DATA_W(DATA_W)) u_pattern (
      .mode       (mode_q),
      .fill_value (fill_q),
      .offset     (offset[DATA_W-1:0]),
      .data       (o_data)
   );

endmodule

// File: tb/tb_fb_filler.sv
// Directed self-checking bench for fb_filler.
module tb_fb_filler;

   localparam int ADDR_W = 26;
   localparam int DATA_W = 8;
   localparam int PACE_W = 10;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [1:0]        mode = '0;
   logic [ADDR_W-1:0] base = '0;
   logic [ADDR_W-1:0] count = '0;
   logic [DATA_W-1:0] fill_value = '0;
   logic [PACE_W-1:0] pace = '0;
   logic              i_ready = 1'b1;
   logic [ADDR_W-1:0] o_address;
   logic [DATA_W-1:0] o_data;
   logic              o_we, busy, done, aborted;

   fb_filler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PACE_W(PACE_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .mode       (mode),
      .base       (base),
      .count      (count),
      .fill_value (fill_value),
      .pace       (pace),
      .o_address  (o_address),
      .o_data     (o_data),
      .o_we       (o_we),
      .i_ready    (i_ready),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // Accepted-write log and pulse counters, sampled mid-cycle.
   logic [ADDR_W-1:0] wr_addr[$];
   logic [DATA_W-1:0] wr_data[$];
   int                wr_cyc[$];
   int                cyc = 0;
   int                done_cnt = 0;
   int                abort_cnt = 0;
   int                done_cyc = 0;

   logic [ADDR_W-1:0] wrap_addr[4] = '{26'h3FFFFFE, 26'h3FFFFFF, 26'h0, 26'h1};
   logic [DATA_W-1:0] wrap_data[4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (!reset) begin
         if (o_we && i_ready) begin
            wr_addr.push_back(o_address);
            wr_data.push_back(o_data);
            wr_cyc.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (aborted) abort_cnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
   endtask

   // Drive a one-cycle start; returns in the first cycle of the operation.
   task automatic launch(input logic [1:0] m, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n,
                         input logic [DATA_W-1:0] f, input logic [PACE_W-1:0] p);
      mode = m; base = b; count = n; fill_value = f; pace = p;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n = 0;
      while (!done && n < limit) begin
         tick();
         n++;
      end
      check(tag, done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, dc, ac;

      // Reset state while reset is held.
      #2;
      check("rst_we", o_we, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_aborted", aborted, 0);
      check("rst_addr", o_address, 0);
      check("rst_data", o_data, 0);
      #10 reset = 1'b0;
      tick();

      // Solid fill, back-to-back: writes on cycles 1..4, done on cycle 5.
      clear_log();
      c0 = cyc;
      launch(2'd0, 26'd100, 26'd4, 8'h29, 10'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1_we%0d", i), o_we, 1);
         check($sformatf("t1_addr%0d", i), o_address, 100 + i);
         check($sformatf("t1_data%0d", i), o_data, 8'h29);
         tick();
      end
      check("t1_done", done, 1);
      check("t1_done_lat", cyc - c0, 5);
      check("t1_we_off", o_we, 0);
      tick();
      check("t1_done_pulse", done, 0);
      check("t1_idle", busy, 0);
      check("t1_nwr", wr_addr.size(), 4);

      // Nibble-replicate with pace 3: o_we every 4th cycle.
      clear_log();
      launch(2'd2, 26'd0, 26'd20, 8'h00, 10'd3);
      wait_done("t2_done", 200);
      tick();
      check("t2_nwr", wr_addr.size(), 20);
      for (int i = 0; i < wr_addr.size() && i < 20; i++) begin
         check($sformatf("t2_addr%0d", i), wr_addr[i], i);
         check($sformatf("t2_data%0d", i), wr_data[i], (i % 16) * 17);
         if (i > 0) check($sformatf("t2_gap%0d", i), wr_cyc[i] - wr_cyc[i-1], 4);
      end
      if (wr_cyc.size() > 0) check("t2_done_lat", done_cyc - wr_cyc[wr_cyc.size()-1], 1);

      // Ramp with i_ready stalled for 5 cycles on the third word.
      clear_log();
      launch(2'd1, 26'd50, 26'd8, 8'h00, 10'd0);
      tick();
      tick();
      i_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_hold_we%0d", i), o_we, 1);
         check($sformatf("t3_hold_addr%0d", i), o_address, 52);
         check($sformatf("t3_hold_data%0d", i), o_data, 2);
         tick();
      end
      i_ready = 1'b1;
      wait_done("t3_done", 50);
      tick();
      check("t3_nwr", wr_addr.size(), 8);
      for (int i = 0; i < wr_addr.size() && i < 8; i++) begin
         check($sformatf("t3_addr%0d", i), wr_addr[i], 50 + i);
         check($sformatf("t3_data%0d", i), wr_data[i], i);
      end

      // Address wrap at the top of the space, xor-checker, pace 1.
      clear_log();
      launch(2'd3, 26'h3FFFFFE, 26'd4, 8'hA5, 10'd1);
      wait_done("t4_done", 50);
      tick();
      check("t4_nwr", wr_addr.size(), 4);
      for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
         check($sformatf("t4_addr%0d", i), wr_addr[i], wrap_addr[i]);
         check($sformatf("t4_data%0d", i), wr_data[i], wrap_data[i]);
         if (i > 0) check($sformatf("t4_gap%0d", i), wr_cyc[i] - wr_cyc[i-1], 2);
      end

      // Abort on the third write, then a normal restart.
      clear_log();
      dc = done_cnt;
      ac = abort_cnt;
      launch(2'd0, 26'd10, 26'd8, 8'h5A, 10'd0);
      tick();
      tick();
      check("t5_third_addr", o_address, 12);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5_we_drop", o_we, 0);
      check("t5_aborted", aborted, 1);
      check("t5_no_done", done, 0);
      check("t5_busy", busy, 0);
      tick();
      check("t5_aborted_pulse", aborted, 0);
      check("t5_nwr", wr_addr.size(), 3);
      check("t5_abort_cnt", abort_cnt - ac, 1);
      check("t5_done_cnt", done_cnt - dc, 0);
      clear_log();
      launch(2'd0, 26'd200, 26'd2, 8'h3C, 10'd0);
      wait_done("t5_restart_done", 20);
      tick();
      check("t5_restart_nwr", wr_addr.size(), 2);
      if (wr_addr.size() == 2) begin
         check("t5_restart_a0", wr_addr[0], 200);
         check("t5_restart_a1", wr_addr[1], 201);
         check("t5_restart_d1", wr_data[1], 8'h3C);
      end

      // Zero-length fill: straight to FINISH, no writes.
      clear_log();
      launch(2'd0, 26'd0, 26'd0, 8'h77, 10'd0);
      check("t6_we", o_we, 0);
      check("t6_busy", busy, 1);
      check("t6_done", done, 1);
      tick();
      check("t6_done_pulse", done, 0);
      check("t6_idle", busy, 0);
      check("t6_nwr", wr_addr.size(), 0);

      // Start while busy is ignored.
      clear_log();
      launch(2'd0, 26'd300, 26'd3, 8'h11, 10'd2);
      tick();
      base = 26'd900;
      count = 26'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t7_done", 50);
      tick();
      check("t7_nwr", wr_addr.size(), 3);
      for (int i = 0; i < wr_addr.size() && i < 3; i++)
         check($sformatf("t7_addr%0d", i), wr_addr[i], 300 + i);
      check("t7_idle", busy, 0);

      // Asynchronous reset mid-fill clears outputs without any pulse.
      dc = done_cnt;
      ac = abort_cnt;
      launch(2'd0, 26'd500, 26'd10, 8'hC3, 10'd0);
      tick();
      check("t8_pre_we", o_we, 1);
      #2 reset = 1'b1;
      #1;
      check("t8_we", o_we, 0);
      check("t8_busy", busy, 0);
      check("t8_done", done, 0);
      check("t8_aborted", aborted, 0);
      check("t8_addr", o_address, 0);
      check("t8_data", o_data, 0);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      check("t8_idle", busy, 0);
      check("t8_done_cnt", done_cnt - dc, 0);
      check("t8_abort_cnt", abort_cnt - ac, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
